// File: rtl/key_event_pkg.sv
// key_event_pkg: shared constants and types for the key event generator.
//   KEY_* : bit index of each button inside key_n
//   rpt_state_e : auto-repeat state machine encoding for the change key
package key_event_pkg;

  localparam int NUM_KEYS   = 3;
  localparam int KEY_CHANGE = 0;
  localparam int KEY_ENTER  = 1;
  localparam int KEY_CANCEL = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/key_event_gen_if.sv
// key_event_gen_if: button-event bus from the input conditioner to the
// operand-select / result-display state machine.
//   change, enter, cancel : one-cycle event pulses, never two in one cycle
//   number_q              : operand captured on the enter pulse
//   master = producer (key_event_gen), slave = consumer
interface key_event_gen_if #(
  parameter int NUM_W = 5
);
  logic             change;
  logic             enter;
  logic             cancel;
  logic [NUM_W-1:0] number_q;

  modport master (output change, enter, cancel, number_q);
  modport slave  (input  change, enter, cancel, number_q);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser + debouncer for one active-low button.
//   clk, rst_n : clock, async active-low reset
//   key_n      : raw button level (0 = pressed)
//   stable     : debounced level (1 = released), resets released
//   press      : combinational, high in the cycle before the edge at which
//                stable flips released -> pressed, so the caller can register
//                its event on that same edge
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic stable,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          diff;
  logic          flip;

  assign diff  = sync[1] != stable;
  // The flip edge is the one that would take the counter to DEBOUNCE_CYCLES,
  // so the counter itself never has to hold that value.
  assign flip  = diff && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign press = flip && stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], key_n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b1;
    end else if (!diff) begin
      cnt    <= '0;
    end else if (flip) begin
      cnt    <= '0;
      stable <= ~stable;
    end else begin
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: turns three raw active-low buttons and the number switches
// into arbitrated, spaced event pulses with auto-repeat on change.
//   clk, rst_n : clock, async active-low reset
//   key_n      : raw buttons, bit 0 change, bit 1 enter, bit 2 cancel (0 = pressed)
//   number     : raw number switches
//   ev         : event bus (change/enter/cancel pulses, captured number_q)
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int NUM_W           = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NUM_W-1:0]    number,
  key_event_gen_if.master     ev
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW     = $clog2(RPT_MAX + 1);

  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] press;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_n  (key_n[k]),
      .stable (stable[k]),
      .press  (press[k])
    );
  end

  // ---------------- number synchroniser + capture ----------------
  logic [NUM_W-1:0] num_s1, num_s2, num_q;

  // ---------------- arbitration / spacing ----------------
  logic chg_q, ent_q, can_q, can_pend;
  logic chg_d, ent_d, can_d, pend_d;
  logic busy, can_req, chg_req;

  // ---------------- repeat FSM ----------------
  rpt_state_e     st, st_d;
  logic [RCW-1:0] rcnt, rcnt_d;
  logic           rpt_fire;
  logic           chg_held;

  assign chg_held = !stable[KEY_CHANGE];

  assign busy    = chg_q | ent_q | can_q;
  assign can_req = press[KEY_CANCEL] | can_pend;
  assign chg_req = press[KEY_CHANGE] | rpt_fire;

  // A cycle right after a pulse emits nothing; only cancel survives it, by
  // being parked in can_pend and emitted on the following (free) cycle.
  always_comb begin
    chg_d  = 1'b0;
    ent_d  = 1'b0;
    can_d  = 1'b0;
    pend_d = 1'b0;
    if (busy) begin
      pend_d = can_req;
    end else begin
      can_d = can_req;
      ent_d = !can_req && press[KEY_ENTER];
      chg_d = !can_req && !press[KEY_ENTER] && chg_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_q    <= 1'b0;
      ent_q    <= 1'b0;
      can_q    <= 1'b0;
      can_pend <= 1'b0;
      num_s1   <= '0;
      num_s2   <= '0;
      num_q    <= '0;
    end else begin
      chg_q    <= chg_d;
      ent_q    <= ent_d;
      can_q    <= can_d;
      can_pend <= pend_d;
      num_s1   <= number;
      num_s2   <= num_s1;
      if (ent_d) num_q <= num_s2;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      rcnt <= '0;
    end else begin
      st   <= st_d;
      rcnt <= rcnt_d;
    end
  end

  // FSM output: a repeat slot is due at the terminal count while still held
  always_comb begin
    rpt_fire = 1'b0;
    case (st)
      DELAY:   rpt_fire = chg_held && (rcnt == RCW'(REPEAT_DELAY - 1));
      REPEAT:  rpt_fire = chg_held && (rcnt == RCW'(REPEAT_PERIOD - 1));
      default: rpt_fire = 1'b0;
    endcase
  end

  // FSM next state. A due slot that loses arbitration keeps the counter at
  // its terminal value, so the repeat is retried next cycle rather than
  // waiting a whole period again.
  always_comb begin
    st_d   = st;
    rcnt_d = rcnt;
    if (can_d) begin
      st_d = IDLE;
    end else if (chg_d && press[KEY_CHANGE]) begin
      st_d   = DELAY;
      rcnt_d = '0;
    end else begin
      case (st)
        DELAY: begin
          if (!chg_held)     st_d = IDLE;
          else if (rpt_fire) begin
            if (chg_d) begin
              st_d   = REPEAT;
              rcnt_d = '0;
            end
          end else           rcnt_d = rcnt + RCW'(1);
        end
        REPEAT: begin
          if (!chg_held)     st_d = IDLE;
          else if (rpt_fire) begin
            if (chg_d) rcnt_d = '0;
          end else           rcnt_d = rcnt + RCW'(1);
        end
        default: st_d = IDLE;
      endcase
    end
    if (st_d == IDLE) rcnt_d = '0;
  end

  assign ev.change   = chg_q;
  assign ev.enter    = ent_q;
  assign ev.cancel   = can_q;
  assign ev.number_q = num_q;

endmodule

// File: tb/tb_key_event_gen.sv
module tb_key_event_gen;

  localparam int NUM_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       key_n;
  logic [NUM_W-1:0] number;

  key_event_gen_if #(.NUM_W(NUM_W)) ev();

  key_event_gen #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8),
    .NUM_W           (NUM_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_n),
    .number (number),
    .ev     (ev)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor, sampled on the falling edge
  int   n_chg = 0, n_ent = 0, n_can = 0;
  int   ent_cyc = -1, can_cyc = -1, viol = 0;
  int   chg_cyc[$];
  logic [NUM_W-1:0] ent_nq = '0;
  logic prev_any = 1'b0;

  always @(negedge clk) begin
    if (ev.change) begin n_chg++; chg_cyc.push_back(cyc); end
    if (ev.enter)  begin n_ent++; ent_cyc = cyc; ent_nq = ev.number_q; end
    if (ev.cancel) begin n_can++; can_cyc = cyc; end
    if (int'(ev.change) + int'(ev.enter) + int'(ev.cancel) > 1) viol++;
    if (prev_any && (ev.change || ev.enter || ev.cancel)) viol++;
    prev_any = ev.change || ev.enter || ev.cancel;
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int qat(input int idx);
    return (idx < chg_cyc.size()) ? chg_cyc[idx] : -1;
  endfunction

  int b, be, bc, t0;
  int rpt_exp[6] = '{6, 26, 34, 42, 50, 58};

  initial begin
    rst_n  = 1'b0;
    key_n  = 3'b111;
    number = '0;
    tick(2);
    chk("rst_change", int'(ev.change), 0);
    chk("rst_enter",  int'(ev.enter),  0);
    chk("rst_cancel", int'(ev.cancel), 0);
    chk("rst_numq",   int'(ev.number_q), 0);
    tick(1);
    rst_n = 1'b1;
    tick(10);
    chk("idle_quiet", n_chg + n_ent + n_can, 0);

    // 1: bounce, then clean hold from t0
    b = n_chg;
    for (int i = 0; i < 6; i++) begin
      key_n[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    t0 = cyc; key_n[0] = 1'b0;
    tick(16);
    key_n[0] = 1'b1;
    tick(20);
    chk("t1_count", n_chg - b, 1);
    chk("t1_cyc", qat(b), t0 + 6);

    // 2: enter and change together -> enter only, no repeat
    b = n_chg; be = n_ent; t0 = cyc;
    key_n[1:0] = 2'b00;
    tick(40);
    key_n = 3'b111;
    tick(20);
    chk("t2_enter", n_ent - be, 1);
    chk("t2_ent_cyc", ent_cyc, t0 + 6);
    chk("t2_change", n_chg - b, 0);

    // 3: auto-repeat
    b = n_chg; t0 = cyc;
    key_n[0] = 1'b0;
    tick(56);
    key_n[0] = 1'b1;
    tick(30);
    chk("t3_count", n_chg - b, 6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("t3_pulse%0d", k), qat(b + k), t0 + rpt_exp[k]);

    // 4: cancel lands in the gap after a repeat pulse -> deferred one cycle
    b = n_chg; bc = n_can; t0 = cyc;
    key_n[0] = 1'b0;
    tick(29);
    key_n[2] = 1'b0;
    tick(40);
    chk("t4_cancel", n_can - bc, 1);
    chk("t4_can_cyc", can_cyc, t0 + 36);
    chk("t4_change", n_chg - b, 3);
    key_n = 3'b111;
    tick(20);
    b = n_chg; t0 = cyc;
    key_n[0] = 1'b0;
    tick(12);
    key_n[0] = 1'b1;
    tick(20);
    chk("t4_repress", n_chg - b, 1);
    chk("t4_repress_cyc", qat(b), t0 + 6);

    // 5: number capture
    number = 5'h13;
    tick(3);
    chk("t5_nq_before", int'(ev.number_q), 0);
    be = n_ent; t0 = cyc;
    key_n[1] = 1'b0;
    tick(12);
    chk("t5_enter", n_ent - be, 1);
    chk("t5_ent_cyc", ent_cyc, t0 + 6);
    chk("t5_nq_at_enter", int'(ent_nq), 'h13);
    number = 5'h07;
    tick(10);
    chk("t5_nq_hold", int'(ev.number_q), 'h13);
    key_n[1] = 1'b1;
    tick(20);

    // 6: reset while repeating with change held
    b = n_chg; t0 = cyc;
    key_n[0] = 1'b0;
    tick(30);
    chk("t6_pre", n_chg - b, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_change", int'(ev.change), 0);
    chk("t6_rst_numq",   int'(ev.number_q), 0);
    tick(3);
    rst_n = 1'b1;
    b = n_chg; t0 = cyc;
    tick(15);
    chk("t6_count", n_chg - b, 1);
    chk("t6_cyc", qat(b), t0 + 6);
    key_n = 3'b111;
    tick(20);

    chk("spacing", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
